// File: rtl/gray_to_rgb_serializer_if.sv
// Pixel-in / subpixel-out handshake bundle for gray_to_rgb_serializer.
// The source/sink side uses master and the serializer uses slave.
interface gray_to_rgb_serializer_if #(
    parameter int P_SUBPIXEL_DEPTH = 8
);
    logic [P_SUBPIXEL_DEPTH-1:0] I_PIXEL;
    logic                        I_VALID;
    logic                        O_READY;
    logic [P_SUBPIXEL_DEPTH-1:0] O_DATA;
    logic [1:0]                  O_CHANNEL;
    logic                        O_VALID;
    logic                        I_READY;
    logic                        O_EOL;

    modport master (
        output I_PIXEL, I_VALID, I_READY,
        input  O_READY, O_DATA, O_CHANNEL, O_VALID, O_EOL
    );

    modport slave (
        input  I_PIXEL, I_VALID, I_READY,
        output O_READY, O_DATA, O_CHANNEL, O_VALID, O_EOL
    );
endinterface

// File: rtl/gray_to_rgb_serializer.sv
// Expands each gray pixel into R,G,B subpixel beats and flags end of line.
// Define GRAY_TO_RGB_FALSECOLOR_EN to select the false-colour beat map.
module gray_to_rgb_serializer #(
    parameter int P_SUBPIXEL_DEPTH  = 8,
    parameter int P_PIXELS_PER_LINE = 640
) (
    input logic I_CLK,
    input logic I_RESET,
    gray_to_rgb_serializer_if.slave bus
);
    localparam int N  = P_SUBPIXEL_DEPTH;
    localparam int CW = (P_PIXELS_PER_LINE > 1) ? $clog2(P_PIXELS_PER_LINE) : 1;
    localparam logic [CW-1:0] LAST = CW'(P_PIXELS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_R,
        S_SEND_G,
        S_SEND_B
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    hold_q, hold_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    data_q, data_d;
    logic [1:0]      chan_q, chan_d;
    logic            eol_q, eol_d;
    logic            ready;
    logic            accept;
    logic            consume;

    assign ready   = !I_RESET &&
                     (state_q == S_IDLE ||
                      (state_q == S_SEND_B && bus.I_READY));
    assign accept  = bus.I_VALID && ready;
    assign consume = (state_q != S_IDLE) && bus.I_READY;

`ifdef GRAY_TO_RGB_FALSECOLOR_EN
    // Triangle ramp for G: rises to full scale at mid-gray, then falls.
    logic [N-1:0] tri_g;
    assign tri_g = hold_d[N-1] ? ~{hold_d[N-2:0], 1'b0}
                               :  {hold_d[N-2:0], 1'b0};
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SEND_R;
                    hold_d  = bus.I_PIXEL;
                end
            end
            S_SEND_R: begin
                if (consume) state_d = S_SEND_G;
            end
            S_SEND_G: begin
                if (consume) state_d = S_SEND_B;
            end
            S_SEND_B: begin
                if (consume) begin
                    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                    if (accept) begin
                        state_d = S_SEND_R;
                        hold_d  = bus.I_PIXEL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        data_d = '0;
        chan_d = 2'd0;
        eol_d  = 1'b0;
        unique case (state_d)
            S_SEND_R: begin
                chan_d = 2'd0;
                data_d = hold_d;
            end
            S_SEND_G: begin
                chan_d = 2'd1;
`ifdef GRAY_TO_RGB_FALSECOLOR_EN
                data_d = tri_g;
`else
                data_d = hold_d;
`endif
            end
            S_SEND_B: begin
                chan_d = 2'd2;
`ifdef GRAY_TO_RGB_FALSECOLOR_EN
                data_d = ~hold_d;
`else
                data_d = hold_d;
`endif
                eol_d  = (cnt_d == LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            chan_q  <= 2'd0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            eol_q   <= eol_d;
        end
    end

    assign bus.O_READY   = ready;
    assign bus.O_VALID   = (state_q != S_IDLE);
    assign bus.O_DATA    = data_q;
    assign bus.O_CHANNEL = chan_q;
    assign bus.O_EOL     = eol_q;
endmodule

// File: tb/tb_gray_to_rgb_serializer.sv
// Scoreboard bench for gray_to_rgb_serializer with a 4-pixel line.
// Honours GRAY_TO_RGB_FALSECOLOR_EN for the expected beat values.
module tb_gray_to_rgb_serializer;
    localparam int PPL = 4;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
        logic       eol;
    } beat_t;

    logic I_CLK = 1'b0;
    logic I_RESET;

    gray_to_rgb_serializer_if #(.P_SUBPIXEL_DEPTH(8)) bus ();

    gray_to_rgb_serializer #(
        .P_SUBPIXEL_DEPTH (8),
        .P_PIXELS_PER_LINE(PPL)
    ) dut (
        .I_CLK  (I_CLK),
        .I_RESET(I_RESET),
        .bus    (bus.slave)
    );

    always #5 I_CLK = ~I_CLK;

    beat_t sb[$];
    int total = 0;
    int bad   = 0;
    int mcnt  = 0;
    int cyc   = 0;
    int nbeats = 0;
    int mark = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fc(input logic [7:0] g, input int ch);
`ifdef GRAY_TO_RGB_FALSECOLOR_EN
        logic [7:0] t;
        t = g[7] ? ~{g[6:0], 1'b0} : {g[6:0], 1'b0};
        if (ch == 0) return g;
        if (ch == 1) return t;
        return ~g;
`else
        fc = g;
        if (ch > 2) fc = '0;
`endif
    endfunction

    // Monitor: every consumed beat is popped and compared
    always @(negedge I_CLK) begin
        beat_t e;
        if (!I_RESET && bus.O_VALID && bus.I_READY) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat got=%0h ch=%0d want=none",
                         bus.O_DATA, bus.O_CHANNEL);
            end else begin
                e = sb.pop_front();
                chk("beat_data", 32'(bus.O_DATA), 32'(e.d));
                chk("beat_chan", 32'(bus.O_CHANNEL), 32'(e.ch));
                chk("beat_eol", 32'(bus.O_EOL), 32'(e.eol));
            end
            if (nbeats == mark) first_cyc = cyc;
            nbeats++;
            last_cyc = cyc;
        end
    end

    task automatic push_pix(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
        logic e;
        e = (mcnt == PPL - 1);
        sb.push_back('{r, 2'd0, 1'b0});
        sb.push_back('{g, 2'd1, 1'b0});
        sb.push_back('{b, 2'd2, e});
        mcnt = (mcnt + 1) % PPL;
    endtask

    // Leaves I_VALID high so back-to-back calls stream without gaps
    task automatic send(input logic [7:0] p, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
        bit acc;
        acc = 0;
        bus.I_PIXEL = p;
        bus.I_VALID = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge I_CLK);
            if (bus.O_READY) begin
                push_pix(r, g, b);
                acc = 1;
            end
            @(posedge I_CLK);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=0 want=1 pix=%0h", p);
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        bus.I_VALID = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge I_CLK);
            if (sb.size() == 0 && !bus.O_VALID) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", 32'(done), 32'd1);
        @(posedge I_CLK);
        #1;
    endtask

    task automatic wait_g();
        bit seen;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.O_VALID && bus.O_CHANNEL == 2'd1) begin
                seen = 1;
                break;
            end
            @(posedge I_CLK);
            #1;
        end
        chk("g_beat_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hg;
        I_RESET     = 1'b1;
        bus.I_VALID = 1'b0;
        bus.I_READY = 1'b0;
        bus.I_PIXEL = 8'h00;

        @(posedge I_CLK);
        #1;
        @(negedge I_CLK);
        chk("rst_ready", 32'(bus.O_READY), 32'd0);
        chk("rst_valid", 32'(bus.O_VALID), 32'd0);
        @(posedge I_CLK);
        #1;
        I_RESET     = 1'b0;
        bus.I_READY = 1'b1;
        @(negedge I_CLK);
        chk("post_rst_valid", 32'(bus.O_VALID), 32'd0);
        chk("post_rst_data", 32'(bus.O_DATA), 32'd0);
        chk("post_rst_chan", 32'(bus.O_CHANNEL), 32'd0);
        chk("post_rst_eol", 32'(bus.O_EOL), 32'd0);
        chk("post_rst_ready", 32'(bus.O_READY), 32'd1);
        @(posedge I_CLK);
        #1;

        // Single pixel: three consecutive beats
        mark = nbeats;
`ifdef GRAY_TO_RGB_FALSECOLOR_EN
        send(8'h5A, 8'h5A, 8'hB4, 8'hA5);
`else
        send(8'h5A, 8'h5A, 8'h5A, 8'h5A);
`endif
        drain();
        chk("single_span", 32'(last_cyc - first_cyc), 32'd2);

        // Backpressure on the G beat
`ifdef GRAY_TO_RGB_FALSECOLOR_EN
        hg = 8'h66;
        send(8'h33, 8'h33, 8'h66, 8'hCC);
`else
        hg = 8'h33;
        send(8'h33, 8'h33, 8'h33, 8'h33);
`endif
        bus.I_VALID = 1'b0;
        wait_g();
        bus.I_READY = 1'b0;
        bus.I_VALID = 1'b1;
        bus.I_PIXEL = 8'h77;
        for (int k = 0; k < 4; k++) begin
            @(negedge I_CLK);
            chk("stall_chan", 32'(bus.O_CHANNEL), 32'd1);
            chk("stall_data", 32'(bus.O_DATA), 32'(hg));
            chk("stall_ready", 32'(bus.O_READY), 32'd0);
            @(posedge I_CLK);
            #1;
        end
        bus.I_VALID = 1'b0;
        bus.I_READY = 1'b1;
        @(posedge I_CLK);
        #1;
        @(negedge I_CLK);
        chk("resume_chan", 32'(bus.O_CHANNEL), 32'd2);
        drain();

        // Stream nine pixels, then three more to see the line wrap
        mark = nbeats;
        for (int i = 0; i < 9; i++)
            send(8'(i), fc(8'(i), 0), fc(8'(i), 1), fc(8'(i), 2));
        drain();
        chk("stream_span", 32'(last_cyc - first_cyc), 32'd26);
        for (int i = 9; i < 12; i++)
            send(8'(i), fc(8'(i), 0), fc(8'(i), 1), fc(8'(i), 2));
        drain();

        // Reset while the G beat is pending
        send(8'h99, fc(8'h99, 0), fc(8'h99, 1), fc(8'h99, 2));
        bus.I_VALID = 1'b0;
        wait_g();
        bus.I_READY = 1'b0;
        I_RESET     = 1'b1;
        @(posedge I_CLK);
        #1;
        I_RESET = 1'b0;
        sb.delete();
        mcnt = 0;
        @(negedge I_CLK);
        chk("rstmid_valid", 32'(bus.O_VALID), 32'd0);
        chk("rstmid_eol", 32'(bus.O_EOL), 32'd0);
        bus.I_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge I_CLK);
            chk("rstmid_no_b", 32'(bus.O_VALID), 32'd0);
        end
        @(posedge I_CLK);
        #1;
        for (int i = 0; i < 4; i++)
            send(8'hA0 + 8'(i), fc(8'hA0 + 8'(i), 0),
                 fc(8'hA0 + 8'(i), 1), fc(8'hA0 + 8'(i), 2));
        drain();

        // Beat mapping at mid-scale points and range ends
`ifdef GRAY_TO_RGB_FALSECOLOR_EN
        send(8'h40, 8'h40, 8'h80, 8'hBF);
        send(8'hC0, 8'hC0, 8'h7F, 8'h3F);
        send(8'h00, 8'h00, 8'h00, 8'hFF);
        send(8'hFF, 8'hFF, 8'h01, 8'h00);
`else
        send(8'h40, 8'h40, 8'h40, 8'h40);
        send(8'hC0, 8'hC0, 8'hC0, 8'hC0);
        send(8'h00, 8'h00, 8'h00, 8'h00);
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
